// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the mm:ss countdown sequencer: state encoding,
// default tick divider and the width of the BCD digit bus.
package countdown_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int TICK_DIV_DEF = 100_000_000;
   localparam int DIGITS_W     = 16;

   function automatic logic digits_zero(input logic [DIGITS_W-1:0] d);
      return (d == '0);
   endfunction

endpackage

// File: rtl/countdown_ctrl_tick_gen.sv
// Prescaler counting 0..TICK_DIV-1; tick_o flags the last count so the
// parent can act on the wrap edge. clr_i overrides en_i.
module countdown_ctrl_tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int            CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/countdown_ctrl.sv
// Start/pause/clear sequencer for a borrow-chained mm:ss BCD down-counter
// chain: issues per-second decrease pulses, reloads, and alarms at 00:00.
module countdown_ctrl
   import countdown_ctrl_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_pause,
   input  logic                clear,
   input  logic [DIGITS_W-1:0] digits,
   output logic                cnt_decrease,
   output logic                cnt_en,
   output logic                cnt_reset_n,
   output logic                running,
   output logic                done,
   output logic                alarm,
   output logic [1:0]          state
);

   state_e state_q, state_d;
   logic   cnt_decrease_q, cnt_decrease_d;
   logic   cnt_en_q;
   logic   cnt_reset_n_q;
   logic   running_q;
   logic   done_q;
   logic   alarm_q, alarm_d;
   logic   presc_en, presc_clr, tick, zero;

   countdown_ctrl_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .en_i  (presc_en),
      .clr_i (presc_clr),
      .tick_o(tick)
   );

   assign zero = digits_zero(digits);

   // clear beats start_pause, which beats tick and zero detection.
   always_comb begin
      state_d        = state_q;
      cnt_decrease_d = 1'b0;
      alarm_d        = alarm_q;
      presc_en       = 1'b0;
      presc_clr      = 1'b0;
      if (clear) begin
         state_d   = ST_IDLE;
         alarm_d   = 1'b0;
         presc_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               presc_clr = 1'b1;
               if (start_pause && !zero) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (start_pause) begin
                  state_d = ST_PAUSE;
               end else if (zero && !cnt_decrease_q) begin
                  // The chain has already absorbed the last pulse.
                  state_d   = ST_DONE;
                  alarm_d   = 1'b1;
                  presc_clr = 1'b1;
               end else begin
                  presc_en       = 1'b1;
                  cnt_decrease_d = tick && !zero;
               end
            end
            ST_PAUSE: begin
               if (start_pause) state_d = ST_RUN;
            end
            ST_DONE: begin
               presc_en = 1'b1;
               if (tick) alarm_d = !alarm_q;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         cnt_decrease_q <= 1'b0;
         cnt_en_q       <= 1'b0;
         cnt_reset_n_q  <= 1'b0;
         running_q      <= 1'b0;
         done_q         <= 1'b0;
         alarm_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_decrease_q <= cnt_decrease_d;
         cnt_en_q       <= 1'b1;
         cnt_reset_n_q  <= !clear;
         running_q      <= (state_d == ST_RUN);
         done_q         <= (state_d == ST_DONE);
         alarm_q        <= alarm_d;
      end
   end

   assign cnt_decrease = cnt_decrease_q;
   assign cnt_en       = cnt_en_q;
   assign cnt_reset_n  = cnt_reset_n_q;
   assign running      = running_q;
   assign done         = done_q;
   assign alarm        = alarm_q;
   assign state        = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl with TICK_DIV=4; the counter chain and the
// expected sequencer behaviour are modelled in seconds and cycle phases.
module tb_countdown_ctrl;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_pause = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] digits = '0;
   logic        cnt_decrease, cnt_en, cnt_reset_n, running, done, alarm;
   logic [1:0]  state;

   int total = 0;
   int bad   = 0;

   // Reference model: mode 0..3 = idle/run/pause/done, phase = cycles into
   // the current second, secs = value held by the modelled counter chain.
   int m_mode, m_phase, m_secs, m_init;
   bit m_dec, m_rldn, m_en, m_alarm;

   countdown_ctrl #(.TICK_DIV(TD)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_pause (start_pause),
      .clear       (clear),
      .digits      (digits),
      .cnt_decrease(cnt_decrease),
      .cnt_en      (cnt_en),
      .cnt_reset_n (cnt_reset_n),
      .running     (running),
      .done        (done),
      .alarm       (alarm),
      .state       (state)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] to_bcd(input int s);
      int mm = s / 60;
      int ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic [7:0] obs_vec();
      return {cnt_decrease, cnt_en, cnt_reset_n, running, done, alarm, state};
   endfunction

   function automatic logic [7:0] exp_vec();
      return {m_dec, m_en, m_rldn, m_mode == 1, m_mode == 3, m_alarm, 2'(m_mode)};
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_phase = 0; m_dec = 0; m_rldn = 0; m_en = 0; m_alarm = 0;
   endfunction

   function automatic void model_edge(input bit sp, input bit cl);
      int old_secs = m_secs;
      bit old_dec  = m_dec;
      if (!m_rldn)                 m_secs = m_init;
      else if (!m_en)              m_secs = 0;
      else if (m_dec && m_secs > 0) m_secs = m_secs - 1;
      m_dec  = 0;
      m_rldn = !cl;
      m_en   = 1;
      if (cl) begin
         m_mode = 0; m_phase = 0; m_alarm = 0;
      end else begin
         case (m_mode)
            0: if (sp && old_secs != 0) begin m_mode = 1; m_phase = 0; end
            1: begin
               if (sp) m_mode = 2;
               else if (old_secs == 0 && !old_dec) begin
                  m_mode = 3; m_phase = 0; m_alarm = 1;
               end else begin
                  m_phase = (m_phase + 1) % TD;
                  if (m_phase == 0) m_dec = (old_secs != 0);
               end
            end
            2: if (sp) m_mode = 1;
            default: begin
               m_phase = (m_phase + 1) % TD;
               if (m_phase == 0) m_alarm = !m_alarm;
            end
         endcase
      end
   endfunction

   task automatic step(input bit sp, input bit cl);
      @(negedge clk);
      start_pause = sp;
      clear       = cl;
      digits      = to_bcd(m_secs);
      @(posedge clk);
      model_edge(sp, cl);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      start_pause = 0;
      clear       = 0;
      reset       = 1;
      #1;
      model_reset();
      @(posedge clk);
      m_secs = m_init;
      @(negedge clk);
      reset = 0;
   endtask

   task automatic reload(input int init);
      m_init = init;
      step(0, 1);
      step(0, 0);
   endtask

   task automatic test_reset();
      m_init = 2;
      @(negedge clk);
      reset = 1;
      #1;
      model_reset();
      total++;
      if (obs_vec() !== 8'h00) begin
         bad++; $display("FAIL reset_outputs got=%b want=%b", obs_vec(), 8'h00);
      end
      @(posedge clk);
      m_secs = m_init;
      @(negedge clk);
      reset = 0;
      step(0, 0);
      total++;
      if ({cnt_en, cnt_reset_n, state} !== 4'b1100) begin
         bad++; $display("FAIL reset_release en/rld/state got=%b want=1100", {cnt_en, cnt_reset_n, state});
      end
      total++;
      if (obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL reset_release_vec got=%b want=%b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_countdown();
      int npulse = 0, done_cyc = -1, toggles = 0;
      int p[2] = '{-1, -1};
      logic prev;
      reload(2);
      step(1, 0);
      total++;
      if (state !== 2'd1 || running !== 1'b1) begin
         bad++; $display("FAIL start_run state=%0d running=%b want 1/1", state, running);
      end
      for (int c = 1; c <= 60; c++) begin
         step(0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL countdown_cyc%0d got=%b want=%b", c, obs_vec(), exp_vec());
         end
         if (cnt_decrease === 1'b1) begin
            if (npulse < 2) p[npulse] = c;
            npulse++;
         end
         if (state === 2'd3) begin
            done_cyc = c;
            break;
         end
      end
      total++;
      if (done_cyc < 0) begin
         bad++; $display("FAIL countdown_timeout got=no DONE want=DONE within 60 cycles");
      end
      total++;
      if (npulse != 2 || p[0] != 4 || p[1] != 8) begin
         bad++; $display("FAIL pulse_schedule got=n%0d at %0d,%0d want=n2 at 4,8", npulse, p[0], p[1]);
      end
      total++;
      if (done_cyc - p[1] != 2 || done !== 1'b1 || alarm !== 1'b1) begin
         bad++; $display("FAIL done_entry got=lag%0d done=%b alarm=%b want=lag2 1 1", done_cyc - p[1], done, alarm);
      end
      prev = alarm;
      for (int c = 1; c <= 12; c++) begin
         step(c == 5, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL done_cyc%0d got=%b want=%b", c, obs_vec(), exp_vec());
         end
         if (cnt_decrease === 1'b1) npulse++;
         if (alarm !== prev) toggles++;
         prev = alarm;
      end
      total++;
      if (toggles != 3 || state !== 2'd3 || npulse != 2) begin
         bad++; $display("FAIL done_hold got=toggles%0d state%0d pulses%0d want=3 3 2", toggles, state, npulse);
      end
      step(0, 1);
      total++;
      if ({cnt_reset_n, state, alarm, done} !== 5'b00000) begin
         bad++; $display("FAIL clear_from_done got=%b want=00000", {cnt_reset_n, state, alarm, done});
      end
      step(0, 0);
      total++;
      if (cnt_reset_n !== 1'b1) begin
         bad++; $display("FAIL clear_rld_width got=%b want=1", cnt_reset_n);
      end
   endtask

   task automatic test_pause();
      reload(5);
      step(1, 0);
      step(0, 0);
      step(0, 0);
      step(1, 0);
      total++;
      if (state !== 2'd2 || running !== 1'b0) begin
         bad++; $display("FAIL pause_enter state=%0d running=%b want 2/0", state, running);
      end
      for (int c = 1; c <= 10; c++) begin
         step(0, 0);
         total++;
         if (cnt_decrease !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL pause_hold%0d got=%b want=%b", c, obs_vec(), exp_vec());
         end
      end
      step(1, 0);
      total++;
      if (state !== 2'd1 || cnt_decrease !== 1'b0) begin
         bad++; $display("FAIL resume state=%0d dec=%b want 1/0", state, cnt_decrease);
      end
      step(0, 0);
      total++;
      if (cnt_decrease !== 1'b0) begin
         bad++; $display("FAIL resume_plus1 dec=%b want 0", cnt_decrease);
      end
      step(0, 0);
      total++;
      if (cnt_decrease !== 1'b1 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL resume_plus2 got=%b want=%b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_clear_priority();
      reload(3);
      step(1, 0);
      step(0, 0);
      step(0, 0);
      step(1, 1);
      total++;
      if ({state, cnt_reset_n, running} !== 4'b0000) begin
         bad++; $display("FAIL clear_vs_sp got=%b want=0000", {state, cnt_reset_n, running});
      end
      step(0, 0);
      total++;
      if (cnt_reset_n !== 1'b1 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL clear_vs_sp_next got=%b want=%b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_zero_start();
      reload(0);
      step(1, 0);
      total++;
      if (state !== 2'd0) begin
         bad++; $display("FAIL zero_start state=%0d want 0", state);
      end
      for (int c = 1; c <= 8; c++) begin
         step(0, 0);
         total++;
         if (cnt_decrease !== 1'b0 || state !== 2'd0) begin
            bad++; $display("FAIL zero_idle%0d dec=%b state=%0d want 0/0", c, cnt_decrease, state);
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         reload(int'($urandom_range(1, 9)));
         for (int c = 0; c < 120; c++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 69) == 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
               bad++; $display("FAIL random_r%0d_c%0d got=%b want=%b", r, c, obs_vec(), exp_vec());
            end
         end
      end
   endtask

   task automatic test_reset_mid_run();
      bit hit = 0;
      reload(3);
      step(1, 0);
      for (int c = 0; c < 20; c++) begin
         step(0, 0);
         if (m_dec) begin
            hit = 1;
            break;
         end
      end
      total++;
      if (!hit || cnt_decrease !== 1'b1) begin
         bad++; $display("FAIL midrun_pulse got=dec%b want=1", cnt_decrease);
      end
      #2;
      reset = 1;
      #1;
      model_reset();
      total++;
      if (obs_vec() !== 8'h00) begin
         bad++; $display("FAIL midrun_reset got=%b want=%b", obs_vec(), 8'h00);
      end
      @(posedge clk);
      m_secs = m_init;
      @(negedge clk);
      reset = 0;
      step(0, 0);
      total++;
      if ({cnt_en, cnt_reset_n, state, cnt_decrease} !== 5'b11000) begin
         bad++; $display("FAIL midrun_release got=%b want=11000", {cnt_en, cnt_reset_n, state, cnt_decrease});
      end
   endtask

   initial begin
      model_reset();
      m_secs = 0;
      m_init = 2;
      test_reset();
      test_countdown();
      test_pause();
      test_clear_priority();
      test_zero_start();
      apply_reset();
      test_random();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
